// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one input stream fanned out to N = 2**sel_bits
// single-entry output slots, plus the accepted-word counter.
interface stream_demux_if #(
    parameter int data_bits = 1,
    parameter int sel_bits  = 1
);
    localparam int N = 2 ** sel_bits;

    logic                           in_valid;
    logic                           in_ready;
    logic [data_bits-1:0]           in_data;
    logic [sel_bits-1:0]            in_sel;
    logic [N-1:0]                   out_valid;
    logic [N-1:0]                   out_ready;
    logic [N-1:0][data_bits-1:0]    out_data;
    logic [15:0]                    xfer_count;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, xfer_count
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, xfer_count
    );
endinterface

// File: rtl/stream_demux.sv
// Stream demultiplexer: routes each accepted input word to the output slot chosen by
// in_sel; every slot is an independent one-deep register with its own valid flag.
module stream_demux #(
    parameter int data_bits = 1,
    parameter int sel_bits  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_demux_if.slave bus
);
    localparam int N = 2 ** sel_bits;

    logic [N-1:0]                valid_q, valid_d;
    logic [N-1:0][data_bits-1:0] data_q, data_d;
    logic [15:0]                 count_q, count_d;
    logic                        in_ready;
    logic                        in_xfer;

    // Slot can take a word if empty or being drained this cycle; never looks at in_valid.
    always_comb begin
        in_ready = ~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel];
        in_xfer  = bus.in_valid & in_ready;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        for (int i = 0; i < N; i++) begin
            if (valid_q[i] && bus.out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
            // A load wins over a drain in the same cycle, keeping full throughput.
            if (in_xfer && (bus.in_sel == sel_bits'(i))) begin
                valid_d[i] = 1'b1;
                data_d[i]  = bus.in_data;
            end
        end
        if (in_xfer) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.xfer_count = count_q;
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with N=4 outputs and 8-bit data.
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    stream_demux_if #(.data_bits(8), .sel_bits(2)) bus ();

    stream_demux #(.data_bits(8), .sel_bits(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid got %b want 0000", bus.out_valid); end
        checks++; if (bus.xfer_count !== 16'h0000) begin fails++; $display("FAIL reset_count got %h want 0000", bus.xfer_count); end
        checks++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        bus.out_ready = 4'hF;
        drive(1'b1, 2'd2, 8'hA1);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0100) begin fails++; $display("FAIL basic_v1 got %b want 0100", bus.out_valid); end
        checks++; if (bus.out_data[2] !== 8'hA1) begin fails++; $display("FAIL basic_d1 got %h want a1", bus.out_data[2]); end
        drive(1'b1, 2'd0, 8'hB2);
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0001) begin fails++; $display("FAIL basic_v2 got %b want 0001", bus.out_valid); end
        checks++; if (bus.out_data[0] !== 8'hB2) begin fails++; $display("FAIL basic_d2 got %h want b2", bus.out_data[0]); end
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL basic_v3 got %b want 0000", bus.out_valid); end
        checks++; if (bus.xfer_count !== 16'd2) begin fails++; $display("FAIL basic_count got %0d want 2", bus.xfer_count); end
    endtask

    task automatic test_stall_and_independent;
        bus.out_ready = 4'b1101;
        drive(1'b1, 2'd1, 8'h11);
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0010) begin fails++; $display("FAIL stall_v1 got %b want 0010", bus.out_valid); end
        checks++; if (bus.out_data[1] !== 8'h11) begin fails++; $display("FAIL stall_d1 got %h want 11", bus.out_data[1]); end
        drive(1'b1, 2'd3, 8'h33);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL indep_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b1010) begin fails++; $display("FAIL indep_v got %b want 1010", bus.out_valid); end
        checks++; if (bus.out_data[3] !== 8'h33) begin fails++; $display("FAIL indep_d got %h want 33", bus.out_data[3]); end
        drive(1'b1, 2'd1, 8'h22);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready0 got %b want 0", bus.in_ready); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 4'b0010) begin fails++; $display("FAIL stall_hold_v%0d got %b want 0010", k, bus.out_valid); end
            checks++; if (bus.out_data[1] !== 8'h11) begin fails++; $display("FAIL stall_hold_d%0d got %h want 11", k, bus.out_data[1]); end
            checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_hold_r%0d got %b want 0", k, bus.in_ready); end
        end
        bus.out_ready = 4'hF;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stall_release got %b want 1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0010) begin fails++; $display("FAIL stall_v2 got %b want 0010", bus.out_valid); end
        checks++; if (bus.out_data[1] !== 8'h22) begin fails++; $display("FAIL stall_d2 got %h want 22", bus.out_data[1]); end
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL stall_drain got %b want 0000", bus.out_valid); end
        checks++; if (bus.xfer_count !== 16'd5) begin fails++; $display("FAIL stall_count got %0d want 5", bus.xfer_count); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        bus.out_ready = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                w = 8'(k);
                checks++; if (bus.out_valid !== 4'b0001) begin fails++; $display("FAIL b2b_v%0d got %b want 0001", k, bus.out_valid); end
                checks++; if (bus.out_data[0] !== w) begin fails++; $display("FAIL b2b_d%0d got %h want %h", k, bus.out_data[0], w); end
            end
            w = 8'(k + 1);
            drive(1'b1, 2'd0, w);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_r%0d got %b want 1", k, bus.in_ready); end
            @(negedge clk);
        end
        checks++; if (bus.out_data[0] !== 8'h10) begin fails++; $display("FAIL b2b_last got %h want 10", bus.out_data[0]); end
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        checks++; if (bus.xfer_count !== 16'd21) begin fails++; $display("FAIL b2b_count got %0d want 21", bus.xfer_count); end
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.out_ready = 4'hF;
        drive(1'b1, 2'd1, 8'h5A);
        repeat (65535) @(negedge clk);
        checks++; if (bus.xfer_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre got %h want ffff", bus.xfer_count); end
        @(negedge clk);
        checks++; if (bus.xfer_count !== 16'h0000) begin fails++; $display("FAIL wrap_post got %h want 0000", bus.xfer_count); end
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
    endtask

    task automatic test_reset_midstream;
        bus.out_ready = 4'b0000;
        drive(1'b1, 2'd0, 8'hC0);
        @(negedge clk);
        drive(1'b1, 2'd2, 8'hC2);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00);
        checks++; if (bus.out_valid !== 4'b0101) begin fails++; $display("FAIL mid_pre got %b want 0101", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL mid_valid got %b want 0000", bus.out_valid); end
        checks++; if (bus.xfer_count !== 16'h0000) begin fails++; $display("FAIL mid_count got %h want 0000", bus.xfer_count); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 4'h0;
        drive(1'b0, 2'd0, 8'h00);
        test_reset();
        test_basic();
        test_stall_and_independent();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The module SHALL have parameter data_bits, default 1, which sets the width of each data bus.
REQ-002 The module SHALL have parameter sel_bits, default 1, which sets the number of destination-select bits; the output count is N = 2**sel_bits.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: clock, rising edge active.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: the input word is offered.
REQ-007 Port in_ready, output, 1 bit: the input word is accepted this cycle when in_valid is also high.
REQ-008 Port in_data, input, data_bits: input word.
REQ-009 Port in_sel, input, sel_bits: destination index of the input word.
REQ-010 Port out_valid, output, N bits: bit i high means output i holds a word.
REQ-011 Port out_ready, input, N bits: bit i high means the consumer takes the word on output i.
REQ-012 Port out_data, output, packed [N-1:0][data_bits-1:0]: entry i is the word held for output i.
REQ-013 Port xfer_count, output, 16 bits: running count of accepted input words.

Function
REQ-014 The module SHALL hold one single-entry register per output i, made of a valid flag and a data field.
REQ-015 in_ready SHALL be combinational: it SHALL equal (NOT out_valid[in_sel]) OR out_ready[in_sel].
- in_ready SHALL NOT depend on in_valid.
REQ-016 An input transfer SHALL occur when in_valid AND in_ready are both high at a rising edge.
- On a transfer, slot in_sel SHALL load in_data and set its valid flag.
- Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-017 An output transfer on slot i SHALL occur when out_valid[i] AND out_ready[i] are both high.
- If no input transfer targets slot i in the same cycle, the valid flag SHALL clear.
REQ-018 A simultaneous output transfer on slot i and input transfer targeting slot i SHALL keep the valid flag high and load the new data.
- This gives a sustained throughput of 1 word/cycle to one destination.
REQ-019 Slots SHALL be independent: a full, stalled slot SHALL NOT block input words targeting other slots.
REQ-020 While in_valid is high and in_ready is low, in_data and in_sel SHALL be required to stay stable; the module SHALL never drop or duplicate a word.
REQ-021 out_data[i] SHALL hold its value while out_valid[i] is high and out_ready[i] is low.
REQ-022 out_data[i] SHALL be don't-care while out_valid[i] is low; implementations SHALL NOT clear it on drain.
REQ-023 xfer_count SHALL increment by 1 on each input transfer and wrap from 16'hFFFF to 16'h0000.
REQ-024 The module SHALL have no combinational path from in_valid or in_data to any out_* port.

Reset
REQ-025 When rst_n is low, all out_valid bits SHALL be 0 and xfer_count SHALL be 0, immediately and independent of clk.
- out_data SHALL reset to 0.
REQ-026 While rst_n is low, in_ready SHALL follow REQ-015 with all slots empty, i.e. 1; no transfer SHALL be recorded.
REQ-027 Reset asserted mid-stream SHALL discard all held words.
- After release, the first transfer SHALL occur on the first rising edge at which rst_n is high.

Verification
REQ-028 Setup N=4, data_bits=8. Words 0xA1 to sel 2 and 0xB2 to sel 0 on consecutive cycles, all out_ready high -> out_valid = 4'b0100 then 4'b0001, each for one cycle, with matching data; xfer_count = 2.
REQ-029 out_ready[1]=0; word 0x11 to sel 1, then word 0x22 to sel 1 -> in_ready low on the second word until out_ready[1] rises; 0x11 is presented first, then 0x22; no loss.
REQ-030 Slot 1 full and stalled; word 0x33 to sel 3 -> accepted at once; out_valid[3] high the next cycle.
REQ-031 Back-to-back words 0x01..0x10 to sel 0 with out_ready[0]=1 -> 16 words in 16 cycles, in_ready constantly 1, order preserved.
REQ-032 Preload xfer_count to 16'hFFFF via 65535 transfers, then one more transfer -> xfer_count = 0.
REQ-033 Assert rst_n low while two slots are valid -> out_valid = 0 and xfer_count = 0 without a clock edge; after release the next word behaves as in REQ-028.
